// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side initiator for the memory-mapped IO bus.
// Turns one 8/16/32-bit load or store into 16-bit bus beats and collects
// read data after the responder's fixed READ_LATENCY address pipeline.
// Optional build macro IO_MASTER_ALIGN_CHECK_EN: a misaligned non-byte
// request is answered with rsp_err=1 and never reaches the bus.
module io_bus_master #(
  parameter int unsigned READ_LATENCY = 2,      // 1..7
  parameter logic [31:0] HI_OFFSET    = 32'd2
) (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_word32,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address_out_io,
  output logic [1:0]  control_out_io,
  output logic [15:0] data_in_io,
  input  logic [15:0] data_out_io
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BEAT = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0] LAT_CNT = 3'(READ_LATENCY);

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rdata_q;
  logic [31:0] bus_addr_q;
  logic [1:0]  bus_ctrl_q;
  logic [15:0] bus_data_q;
  logic        byte_q;
  logic        word32_q;
  logic        half_q;
  logic [2:0]  cnt_q;
  logic [31:0] lo_addr_q;
  logic [31:0] wdata_q;

  logic [31:0] in_lo_addr;
  logic [31:0] hi_addr;

  // Non-byte beats are always halfword aligned on the bus.
  assign in_lo_addr = req_byte ? req_addr : (req_addr & 32'hFFFF_FFFE);
  assign hi_addr    = (lo_addr_q + HI_OFFSET) & 32'hFFFF_FFFE;

`ifdef IO_MASTER_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = !req_byte && (req_addr[0] || (req_word32 && req_addr[1]));
`endif

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rdata_q;
  assign address_out_io = bus_addr_q;
  assign control_out_io = bus_ctrl_q;
  assign data_in_io     = bus_data_q;

  // Request sequencer: accepts a request, issues its beats, returns one response.
  always_ff @(posedge main_clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // only takes effect on the next edge; an in-flight transfer is abandoned.
    if (main_rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_ctrl_q  <= '0;
      bus_data_q  <= '0;
      byte_q      <= 1'b0;
      word32_q    <= 1'b0;
      half_q      <= 1'b0;
      cnt_q       <= '0;
      lo_addr_q   <= '0;
      wdata_q     <= '0;
    end else begin
      // NOTE: every state register uses <= so all updates see pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            byte_q      <= req_byte;
            word32_q    <= req_word32 && !req_byte;
            lo_addr_q   <= in_lo_addr;
            wdata_q     <= req_wdata;
            half_q      <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
`ifdef IO_MASTER_ALIGN_CHECK_EN
            if (misalign) begin
              state_q <= RESP;
            end else
`endif
            if (req_write) begin
              state_q    <= WR_BEAT;
              bus_addr_q <= in_lo_addr;
              bus_ctrl_q <= {1'b1, req_byte};
              bus_data_q <= req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata[15:0];
            end else begin
              state_q    <= RD_WAIT;
              bus_addr_q <= in_lo_addr;
              bus_ctrl_q <= {1'b0, req_byte};
            end
          end
        end

        WR_BEAT: begin
          if (word32_q && !half_q) begin
            half_q     <= 1'b1;
            bus_addr_q <= hi_addr;
            bus_data_q <= wdata_q[31:16];
            bus_ctrl_q <= 2'b10;
          end else begin
            bus_ctrl_q  <= 2'b00;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        RD_WAIT: begin
          if (cnt_q == LAT_CNT) begin
            if (byte_q) begin
              rdata_q <= {24'd0, data_out_io[7:0]};
            end else if (half_q) begin
              rdata_q[31:16] <= data_out_io;
            end else begin
              rdata_q[15:0] <= data_out_io;
            end
            if (word32_q && !half_q) begin
              half_q     <= 1'b1;
              bus_addr_q <= hi_addr;
              cnt_q      <= '0;
            end else begin
              bus_ctrl_q  <= 2'b00;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        RESP: begin
`ifdef IO_MASTER_ALIGN_CHECK_EN
          // Error path enters RESP with no pulse yet; raise it one cycle later.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else
`endif
          begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: randomized and directed checks of io_bus_master against
// a transaction-level model that predicts the per-cycle bus trace and the response.
module tb_io_bus_master;

  localparam int          RL     = 2;
  localparam logic [31:0] HI_OFS = 32'd2;

  logic        main_clk = 1'b0;
  logic        main_rst;
  logic        req_valid, req_ready, req_write, req_byte, req_word32;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address_out_io;
  logic [1:0]  control_out_io;
  logic [15:0] data_in_io, data_out_io;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  c;
    logic [15:0] d;
    bit          av;
    bit          dv;
  } beat_t;

  io_bus_master #(.READ_LATENCY(RL), .HI_OFFSET(HI_OFS)) dut (
    .main_clk       (main_clk),
    .main_rst       (main_rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_byte       (req_byte),
    .req_word32     (req_word32),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .address_out_io (address_out_io),
    .control_out_io (control_out_io),
    .data_in_io     (data_in_io),
    .data_out_io    (data_out_io)
  );

  always #5 main_clk = ~main_clk;

  // Device contents seen by the responder.
  function automatic logic [15:0] mem16(input logic [31:0] a);
    case (a)
      32'h0800_0000: return 16'h1234;
      32'h0800_0002: return 16'h5678;
      32'h0800_0005: return 16'hA5C3;
      default:       return a[15:0] ^ a[31:16] ^ 16'h9E37;
    endcase
  endfunction

  // Responder: address pipeline of RL registers, then a lookup.
  logic [31:0] pipe [RL] = '{default: 32'd0};
  always @(posedge main_clk) begin
    pipe[0] <= address_out_io;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign data_out_io = mem16(pipe[RL-1]);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_junk();
    req_valid  = 1'b1;
    req_write  = 1'($urandom);
    req_byte   = 1'($urandom);
    req_word32 = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Issue one request and compare the full bus trace and the response.
  task automatic do_txn(input bit wr, input bit by, input bit w32,
                        input logic [31:0] addr, input logic [31:0] wd);
    beat_t       exp_q[$];
    beat_t       b;
    int          exp_lat;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          is32, seen, bad_align;
    logic [31:0] base, hi, ba;
    logic [15:0] m_lo, m_hi;
    int          nbeats;

    is32   = w32 && !by;
    nbeats = is32 ? 2 : 1;
    base   = by ? addr : {addr[31:1], 1'b0};
    hi     = base + HI_OFS;
    hi[0]  = 1'b0;
    m_lo   = mem16(base);
    m_hi   = mem16(hi);
    bad_align = 1'b0;
`ifdef IO_MASTER_ALIGN_CHECK_EN
    bad_align = !by && (addr[0] || (w32 && addr[1]));
`endif
    exp_err = 1'b0;
    exp_rd  = 32'd0;
    if (bad_align) begin
      b = '{a: 32'd0, c: 2'b00, d: 16'd0, av: 1'b0, dv: 1'b0};
      exp_q.push_back(b);
      exp_lat = 2;
      exp_err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < nbeats; i++) begin
        ba = (i == 0) ? base : hi;
        b.a = ba; b.c = {1'b1, by}; b.av = 1'b1; b.dv = 1'b1;
        b.d = by ? {wd[7:0], wd[7:0]} : ((i == 0) ? wd[15:0] : wd[31:16]);
        exp_q.push_back(b);
      end
      exp_lat = nbeats + 1;
    end else begin
      for (int i = 0; i < nbeats; i++) begin
        for (int j = 0; j <= RL; j++) begin
          b = '{a: (i == 0) ? base : hi, c: {1'b0, by}, d: 16'd0, av: 1'b1, dv: 1'b0};
          exp_q.push_back(b);
        end
      end
      exp_lat = nbeats * (RL + 1) + 1;
      if (by)        exp_rd = {24'd0, m_lo[7:0]};
      else if (is32) exp_rd = {m_hi, m_lo};
      else           exp_rd = {16'd0, m_lo};
    end

    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_byte = by; req_word32 = w32;
    req_addr = addr; req_wdata = wd;
    @(negedge main_clk);
    seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (rsp_valid) begin
        req_valid = 1'b0;
        check("rsp_lat",   64'(k),         64'(exp_lat));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_err",   64'(rsp_err),   64'(exp_err));
        check("rsp_ctrl",  64'(control_out_io), 64'd0);
        seen = 1'b1;
        @(negedge main_clk);
        check("rsp_pulse", 64'(rsp_valid), 64'd0);
        break;
      end
      if (k - 1 < exp_q.size()) begin
        b = exp_q[k-1];
        if (b.dv)
          check("bus_wr", {address_out_io, control_out_io, data_in_io}, {b.a, b.c, b.d});
        else if (b.av)
          check("bus_rd", 64'({address_out_io, control_out_io}), 64'({b.a, b.c}));
        else
          check("bus_quiet", 64'(control_out_io), 64'(b.c));
      end
      drive_junk();
      @(negedge main_clk);
    end
    if (!seen) check("rsp_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  // Reset in the cycle after a 32-bit store is accepted: only the low beat escapes.
  task automatic reset_mid_store();
    int strobes = 0;
    int rsps = 0;
    check("ready_pre_rst", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_word32 = 1'b1;
    req_addr = 32'h0400_0100; req_wdata = 32'hDEAD_BEEF;
    @(negedge main_clk);
    if (control_out_io[1]) strobes++;
    if (rsp_valid) rsps++;
    req_valid = 1'b0;
    main_rst  = 1'b1;
    @(negedge main_clk);
    if (control_out_io[1]) strobes++;
    if (rsp_valid) rsps++;
    main_rst = 1'b0;
    @(negedge main_clk);
    check("rst_ready_after", 64'(req_ready), 64'd1);
    check("rst_addr_after",  64'(address_out_io), 64'd0);
    for (int k = 0; k < 5; k++) begin
      if (control_out_io[1]) strobes++;
      if (rsp_valid) rsps++;
      @(negedge main_clk);
    end
    check("rst_strobes", 64'(strobes), 64'd1);
    check("rst_no_rsp",  64'(rsps),    64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idle_bad = 0;
    int kind;
    main_rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_word32 = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge main_clk);
    main_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge main_clk);
      if (rsp_valid || control_out_io != 2'b00 || !req_ready) idle_bad++;
    end
    check("idle_bad_cycles", 64'(idle_bad),       64'd0);
    check("reset_ready",     64'(req_ready),      64'd1);
    check("reset_ctrl",      64'(control_out_io), 64'd0);
    check("reset_addr",      64'(address_out_io), 64'd0);
    check("reset_data",      64'(data_in_io),     64'd0);
    check("reset_rdata",     64'(rsp_rdata),      64'd0);

    do_txn(1'b1, 1'b0, 1'b0, 32'h0400_0010, 32'h0000_0ABC);  // 16-bit store
    do_txn(1'b0, 1'b0, 1'b1, 32'h0800_0000, 32'h0);          // 32-bit load
    do_txn(1'b0, 1'b1, 1'b0, 32'h0800_0005, 32'h0);          // byte load
    do_txn(1'b1, 1'b0, 1'b1, 32'h0C00_0020, 32'h89AB_CDEF);  // 32-bit store
    do_txn(1'b1, 1'b1, 1'b1, 32'h0C00_0031, 32'h0000_005A);  // byte wins over word32
    do_txn(1'b0, 1'b1, 1'b1, 32'h0800_0005, 32'h0);          // byte wins over word32
    reset_mid_store();
`ifdef IO_MASTER_ALIGN_CHECK_EN
    do_txn(1'b1, 1'b0, 1'b0, 32'h0400_0003, 32'h0000_1111);  // misaligned store
    do_txn(1'b0, 1'b0, 1'b1, 32'h0800_0002, 32'h0);          // 32-bit on addr[1]
`else
    do_txn(1'b1, 1'b0, 1'b0, 32'h0400_0003, 32'h0000_1111);  // bit0 forced low
`endif

    for (int n = 0; n < 50; n++) begin
      kind = $urandom_range(0, 3);
      do_txn(1'($urandom), kind == 0 || kind == 3, kind == 2 || kind == 3,
             {6'($urandom_range(0, 63)), 26'($urandom)}, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- CPU-side initiator for the memory-mapped IO bus.
- Converts single-request CPU loads/stores (8/16/32-bit) into 16-bit IO bus beats on address_out_io/control_out_io/data_in_io.
- Captures read data from data_out_io after the responder's fixed two-register address pipeline.
- Sits between the core's load/store unit and the IO decoder that serves device slots selected by address[31:26].

Parameters:
- READ_LATENCY, 2, cycles from the first cycle an address is driven to the cycle data_out_io is valid for it; legal range 1..7.
- HI_OFFSET, 2, byte offset added to req_addr for the high half of a 32-bit access.

Ports:
- main_clk  input  1  single clock, shared with the IO responder.
- main_rst  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  master idle; the request is accepted when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_byte  input  1  byte access; overrides req_word32.
- req_word32  input  1  32-bit access, split into two 16-bit beats (low half first).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  one-cycle pulse: load data valid, or store complete.
- rsp_rdata  output  32  load result; 0 for stores.
- rsp_err  output  1  valid with rsp_valid; see Optional Feature.
- address_out_io  output  32  bus address, registered.
- control_out_io  output  2  {write strobe, byte op}, registered.
- data_in_io  output  16  bus write data, registered.
- data_out_io  input  16  bus read data from the responder.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, address_out_io=0, control_out_io=0, data_in_io=0, FSM=IDLE.
- FSM states: IDLE, WR_BEAT, RD_WAIT, RESP.
- IDLE: req_ready=1. On accept, latch all req_* fields and set half=0.
  - Store: go to WR_BEAT.
  - Load: go to RD_WAIT with cnt=0.
  - The bus outputs take the new values on the same edge, so the first bus cycle directly follows the accept cycle.
- WR_BEAT (one cycle per beat): control_out_io[1]=1 for exactly this cycle.
  - Half word: address_out_io = req_addr with bit0 forced 0; data_in_io = wdata[15:0].
  - Byte: address_out_io = req_addr; data_in_io = {wdata[7:0], wdata[7:0]}; control_out_io[0]=1.
  - 32-bit, half 0 sends wdata[15:0]; half 1 sends wdata[31:16] at address + HI_OFFSET. The high beat issues in the cycle immediately after the low beat (two consecutive strobes).
  - After the last beat, go to RESP.
- RD_WAIT: address_out_io and control_out_io[0] are held constant; control_out_io[1]=0.
  - cnt increments each cycle.
  - In the cycle where cnt == READ_LATENCY, data_out_io is sampled:
    - byte: low byte is zero-extended.
    - half: the 16-bit value is placed in the selected half.
  - For a 32-bit load, if half==0, set half=1, drive address + HI_OFFSET, reset cnt=0, and stay in RD_WAIT. Otherwise go to RESP.
  - A 16-bit load therefore occupies the bus for READ_LATENCY+1 cycles; a 32-bit load occupies 2*(READ_LATENCY+1) cycles.
- RESP: rsp_valid=1 for one cycle, rsp_rdata holds the assembled result, control_out_io=0, then return to IDLE.
  - A new request can be accepted in the cycle after RESP.
- Bus idle: control_out_io=0; address_out_io and data_in_io keep their last values.
- req_byte and req_word32 both set: byte access, single beat.
- main_rst mid-operation: abort next edge, no rsp_valid, outputs return to reset values. A partially issued 32-bit store is not rolled back.
- Inputs are ignored while req_ready=0. Only one request is outstanding at a time.

Optional Feature:
- Macro: IO_MASTER_ALIGN_CHECK_EN.
- Defined: a non-byte request with req_addr[0]=1, or a 32-bit request with req_addr[1]=1, issues no bus activity. The FSM goes straight to RESP with rsp_err=1 and rsp_rdata=0, and the latency is 2 cycles from accept to rsp_valid.
- Undefined: rsp_err is tied to 0 and address bit0 is forced to 0 on non-byte beats; no check is made.

Test Plan:
- Reset, then idle 5 cycles -> req_ready=1, control_out_io=0, address_out_io=0, rsp_valid never asserted.
- 16-bit store, addr 0x0400_0010, wdata 0x0000_0ABC -> one cycle with control_out_io=2'b10, address 0x0400_0010, data_in_io 0x0ABC; rsp_valid 2 cycles after accept.
- 32-bit load, addr 0x0800_0000; responder model returns 0x1234 and 0x5678 for the two addresses -> beats at 0x0800_0000 then 0x0800_0002, each held 3 cycles; rsp_rdata=0x5678_1234.
- Byte load, addr 0x0800_0005; responder drives 0xA5C3 -> control_out_io[0]=1 held throughout the wait; rsp_rdata=0x0000_00C3.
- main_rst asserted in the second cycle of a 32-bit store -> exactly one strobe seen, no rsp_valid, req_ready=1 the cycle after reset is released.
- With IO_MASTER_ALIGN_CHECK_EN: 16-bit store to 0x0400_0003 -> no strobe; rsp_valid with rsp_err=1, 2 cycles after accept.
